// File: rtl/cuber_pkg.sv
// Shared constants and FSM state encoding for the cuber block.
// Widths are fixed here; the cube datapath relies on them.
package cuber_pkg;

    localparam int IN_W    = 8;
    localparam int SQ_W    = 2 * IN_W;
    localparam int OUT_W   = 24;
    localparam int LATENCY = 20;
    localparam int MUL_BITS = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SQ_START = 3'd1,
        SQ_WAIT  = 3'd2,
        CU_START = 3'd3,
        CU_WAIT  = 3'd4
    } state_e;

endpackage

// File: rtl/cuber_mul.sv
// Sequential shift-add multiplier, 16x8 -> 24 bits.
// One multiplier bit per cycle; busy for 8 cycles after a start.
module cuber_mul
    import cuber_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [SQ_W-1:0]     a_bi,
    input  logic [IN_W-1:0]     b_bi,
    output logic                busy_o,
    output logic [OUT_W-1:0]    y_bo
);

    logic               busy_q, busy_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [OUT_W-1:0]   a_sh_q, a_sh_d;
    logic [IN_W-1:0]    b_q, b_d;

    // Load operands on start, then add one shifted partial product per cycle
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        a_sh_d = a_sh_q;
        b_d    = b_q;
        if (busy_q) begin
            if (b_q[0]) begin
                acc_d = acc_q + a_sh_q;
            end
            a_sh_d = a_sh_q << 1;
            b_d    = b_q >> 1;
            cnt_d  = cnt_q - 4'd1;
            busy_d = (cnt_q != 4'd1);
        end else if (start_i) begin
            acc_d  = '0;
            a_sh_d = {{(OUT_W-SQ_W){1'b0}}, a_bi};
            b_d    = b_bi;
            cnt_d  = 4'(MUL_BITS);
            busy_d = 1'b1;
        end
    end

    // Multiplier state registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            a_sh_q <= '0;
            b_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            a_sh_q <= a_sh_d;
            b_q    <= b_d;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = acc_q;

endmodule

// File: rtl/cuber.sv
// Cube unit: y = a^3 via two passes through one shared multiplier.
// Optional done_o pulse is built when CUBER_DONE_EN is defined.
module cuber
    import cuber_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IN_W-1:0]     a_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic [OUT_W-1:0]    y_bo
`ifdef CUBER_DONE_EN
    ,
    output logic                done_o
`endif
);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    x_q, x_d;
    logic [SQ_W-1:0]    sq_q, sq_d;
    logic [OUT_W-1:0]   y_q, y_d;
    logic               busy_q, busy_d;
    logic               mul_start_q, mul_start_d;
    logic [SQ_W-1:0]    mul_a;
    logic [IN_W-1:0]    mul_b;
    logic               mul_busy;
    logic [OUT_W-1:0]   mul_y;
`ifdef CUBER_DONE_EN
    logic               done_q, done_d;
`endif

    cuber_mul u_mul (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (mul_start_q),
        .a_bi    (mul_a),
        .b_bi    (mul_b),
        .busy_o  (mul_busy),
        .y_bo    (mul_y)
    );

    // Next-state, operand select and result capture for the square/cube sequence
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        sq_d    = sq_q;
        y_d     = y_q;
        mul_a   = '0;
        mul_b   = '0;
`ifdef CUBER_DONE_EN
        done_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = a_i;
                    state_d = SQ_START;
                end
            end
            SQ_START: begin
                mul_a   = {{(SQ_W-IN_W){1'b0}}, x_q};
                mul_b   = x_q;
                state_d = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (!mul_busy && !mul_start_q) begin
                    sq_d    = mul_y[SQ_W-1:0];
                    state_d = CU_START;
                end
            end
            CU_START: begin
                mul_a   = sq_q;
                mul_b   = x_q;
                state_d = CU_WAIT;
            end
            CU_WAIT: begin
                if (!mul_busy && !mul_start_q) begin
                    y_d     = mul_y;
                    state_d = IDLE;
`ifdef CUBER_DONE_EN
                    done_d  = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        mul_start_d = (state_d == SQ_START) || (state_d == CU_START);
    end

    // FSM and registered outputs; reset aborts any computation in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            x_q         <= '0;
            sq_q        <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
`ifdef CUBER_DONE_EN
            done_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            sq_q        <= sq_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            mul_start_q <= mul_start_d;
`ifdef CUBER_DONE_EN
            done_q      <= done_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = y_q;
`ifdef CUBER_DONE_EN
    assign done_o = done_q;
`endif

endmodule

// File: tb/tb_cuber.sv
// Self-checking bench for cuber with a queue scoreboard of expected cubes.
// Covers reset, sweep, ignored starts, reset abort and back-to-back use.
module tb_cuber;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a_i;
    logic        start_i;
    logic        busy_o;
    logic [23:0] y_bo;
`ifdef CUBER_DONE_EN
    logic        done_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_q[$];

    cuber dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .a_i     (a_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
`ifdef CUBER_DONE_EN
        ,
        .done_o  (done_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] cube(input logic [7:0] a);
        logic [23:0] w;
        w = {16'd0, a};
        return w * w * w;
    endfunction

    function automatic logic get_done();
`ifdef CUBER_DONE_EN
        return done_o;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one start pulse; returns busy_o seen just after the accept edge
    task automatic issue(input logic [7:0] a, output logic acc);
        @(negedge clk);
        a_i = a;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        acc = busy_o;
        exp_q.push_back(cube(a));
        start_i = 1'b0;
    endtask

    // Wait for busy_o to fall (bounded); returns edges counted and outputs
    task automatic wait_fall(output int cyc, output logic [23:0] y,
                             output logic dn);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (busy_o && cyc < 100);
        y  = y_bo;
        dn = get_done();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_i = 8'd0;
        start_i = 1'b0;
        #2;
        checks++;
        if (busy_o !== 1'b0 || y_bo !== 24'd0 || get_done() !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b y=%h done=%b required 0/0/0",
                     busy_o, y_bo, get_done());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        logic acc, dn;
        int cyc;
        logic [23:0] y, e;
        issue(8'd0, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL zero_accept: busy=%b required 1", acc);
        end
        wait_fall(cyc, y, dn);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 20) begin
            errors++;
            $display("FAIL zero_latency: got %0d required 20", cyc);
        end
        checks++;
        if (y !== e || y !== 24'h000000) begin
            errors++;
            $display("FAIL zero_result: got %h required 000000", y);
        end
`ifdef CUBER_DONE_EN
        checks++;
        if (dn !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: got %b required 1", dn);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_width: got %b required 0", done_o);
        end
`endif
    endtask

    task automatic test_corners();
        logic [7:0] av[3];
        logic [23:0] cv[3];
        logic acc, dn;
        int cyc;
        logic [23:0] y, e;
        av[0] = 8'd1;   cv[0] = 24'd1;
        av[1] = 8'd15;  cv[1] = 24'h000D2F;
        av[2] = 8'd255; cv[2] = 24'hFD02FF;
        for (int i = 0; i < 3; i++) begin
            issue(av[i], acc);
            wait_fall(cyc, y, dn);
            e = exp_q.pop_front();
            checks++;
            if (y !== cv[i] || y !== e) begin
                errors++;
                $display("FAIL corner a=%0d: got %h required %h",
                         av[i], y, cv[i]);
            end
            checks++;
            if (cyc !== 20) begin
                errors++;
                $display("FAIL corner_latency a=%0d: got %0d required 20",
                         av[i], cyc);
            end
        end
    endtask

    task automatic test_sweep();
        logic acc, dn;
        int cyc;
        logic [23:0] y, e;
        for (int a = 0; a < 256; a++) begin
            issue(8'(a), acc);
            wait_fall(cyc, y, dn);
            e = exp_q.pop_front();
            checks++;
            if (y !== e || cyc !== 20) begin
                errors++;
                $display("FAIL sweep a=%0d: got %h/%0d required %h/20",
                         a, y, cyc, e);
            end
`ifdef CUBER_DONE_EN
            checks++;
            if (dn !== 1'b1) begin
                errors++;
                $display("FAIL sweep_done a=%0d: got %b required 1", a, dn);
            end
`endif
        end
    endtask

    task automatic test_ignore_busy_start();
        logic acc;
        int cyc;
        int dn_cnt;
        logic [23:0] e;
        issue(8'd7, acc);
        a_i = 8'd9;
        start_i = 1'b1;
        cyc = 0;
        dn_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 15) start_i = 1'b0;
            if (get_done()) dn_cnt++;
        end while (busy_o && cyc < 100);
        e = exp_q.pop_front();
        checks++;
        if (y_bo !== e || y_bo !== 24'd343 || cyc !== 20) begin
            errors++;
            $display("FAIL ignore: got %0d/%0d required 343/20", y_bo, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (busy_o) cyc = -1;
        end
        checks++;
        if (cyc == -1 || y_bo !== 24'd343) begin
            errors++;
            $display("FAIL ignore_restart: busy=%b y=%0d required 0/343",
                     busy_o, y_bo);
        end
`ifdef CUBER_DONE_EN
        checks++;
        if (dn_cnt !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d required 1", dn_cnt);
        end
`endif
    endtask

    task automatic test_reset_abort();
        logic acc, dn;
        int cyc;
        logic [23:0] y, e;
        issue(8'd10, acc);
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        checks++;
        if (busy_o !== 1'b0 || y_bo !== 24'd0 || get_done() !== 1'b0) begin
            errors++;
            $display("FAIL abort: busy=%b y=%h done=%b required 0/0/0",
                     busy_o, y_bo, get_done());
        end
        @(negedge clk);
        rst_n = 1'b1;
        a_i = 8'd3;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(cube(8'd3));
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_accept: busy=%b required 1", busy_o);
        end
        wait_fall(cyc, y, dn);
        e = exp_q.pop_front();
        checks++;
        if (y !== e || y !== 24'd27 || cyc !== 20) begin
            errors++;
            $display("FAIL abort_restart: got %0d/%0d required 27/20", y, cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, dn;
        int cyc1, cyc2;
        logic [23:0] y1, y2, e;
        issue(8'd2, acc);
        wait_fall(cyc1, y1, dn);
        e = exp_q.pop_front();
        checks++;
        if (y1 !== e || y1 !== 24'd8 || cyc1 !== 20) begin
            errors++;
            $display("FAIL b2b_first: got %0d/%0d required 8/20", y1, cyc1);
        end
        a_i = 8'd4;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(cube(8'd4));
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b required 1", busy_o);
        end
        wait_fall(cyc2, y2, dn);
        e = exp_q.pop_front();
        checks++;
        if (y2 !== e || y2 !== 24'd64 || cyc2 + 1 !== 21) begin
            errors++;
            $display("FAIL b2b_second: got %0d spacing %0d required 64/21",
                     y2, cyc2 + 1);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_corners();
        test_sweep();
        test_ignore_busy_start();
        test_reset_abort();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cuber.md
CUBER -- requirements
Module: cuber

Interface
REQ-001 Parameter: none; widths fixed by cuber_pkg constants (IN_W=8, OUT_W=24, LATENCY=20).
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 a_i  input  8  unsigned operand, sampled only when a start is accepted.
REQ-005 start_i  input  1  start request, level-sampled each edge.
REQ-006 busy_o  output  1  high while a computation is in progress (state != IDLE).
REQ-007 y_bo  output  24  unsigned result a_i^3, held stable between completions.
REQ-008 done_o  output  1  one-cycle completion pulse; present only when CUBER_DONE_EN is defined.

Function
REQ-009 The block SHALL compute y_bo = a*a*a exactly (max 255^3 = 0xFD02FF fits 24 bits; no overflow possible).
REQ-010 Start SHALL be accepted only in IDLE with start_i=1; a_i is latched into an internal 8-bit register at that edge.
REQ-011 start_i while busy_o=1 SHALL be ignored, with no effect on the running computation or its result.
REQ-012 FSM states: IDLE, SQ_START, SQ_WAIT, CU_START, CU_WAIT.
REQ-013 IDLE -> SQ_START on accepted start; SQ_START issues multiplier start with operands (x, x) -> SQ_WAIT.
REQ-014 SQ_WAIT holds until multiplier reports not busy and its start is deasserted; square (16 bits) captured -> CU_START.
REQ-015 CU_START issues multiplier start with operands (square, x) -> CU_WAIT; CU_WAIT on completion loads y_bo -> IDLE.
REQ-016 busy_o SHALL rise at the edge accepting start and fall exactly 20 clock edges later; y_bo updates on that same edge.
REQ-017 A new start asserted in the first IDLE cycle after busy_o falls SHALL be accepted (back-to-back throughput 21 cycles).
REQ-018 y_bo SHALL change only at completion; it SHALL NOT show intermediate products.
REQ-019 a_i changes after acceptance SHALL NOT affect the result.

Reset
REQ-020 rst_ni=0 SHALL immediately (asynchronously) force state=IDLE, busy_o=0, y_bo=0, done_o=0, multiplier start=0, and clear the multiplier.
REQ-021 Reset mid-operation SHALL abort the computation; the first start after release computes from scratch with nominal latency.
REQ-022 Reset release SHALL be followed by normal start acceptance on the next edge.

Configuration
REQ-023 Macro CUBER_DONE_EN: when defined, done_o exists and pulses high for exactly one cycle, coincident with the edge on which y_bo updates and busy_o falls.
REQ-024 Without CUBER_DONE_EN, the done_o port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 cuber_pkg SHALL hold the FSM state enum, IN_W, OUT_W, and LATENCY constants.
REQ-026 One sub-module, cuber_mul: sequential shift-add multiplier, 16-bit x 8-bit -> 24-bit.
REQ-027 cuber_mul ports: clk_i, rst_ni, start_i, a_bi[15:0], b_bi[7:0], busy_o, y_bo[23:0].
REQ-028 cuber_mul SHALL process one multiplier bit per cycle.
REQ-029 cuber_mul busy_o SHALL be high for 8 cycles after start; y_bo SHALL be valid when busy_o falls.
REQ-030 cuber_mul SHALL be instantiated once and reused for both products.

Verification
REQ-031 a_i=0, start pulse -> busy_o high 20 cycles, y_bo=0x000000.
REQ-032 Sweep a_i=1, 15, 255 -> y_bo=1, 3375 (0x000D2F), 16581375 (0xFD02FF); full 0..255 sweep vs model.
REQ-033 a_i=7 accepted, then start_i=1 with a_i=9 during busy -> single completion with y_bo=343; no restart.
REQ-034 a_i=10 accepted, rst_ni low at cycle 8 -> busy_o=0, y_bo=0 immediately; next start a_i=3 -> y_bo=27 after 20 cycles.
REQ-035 Back-to-back: start a_i=2, start a_i=4 held in first IDLE cycle -> results 8 then 64, 21-cycle spacing.
REQ-036 With CUBER_DONE_EN: done_o high exactly one cycle per completion, aligned with the y_bo update; never high after reset abort.
